// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   BEAT_CNT_W  : width of the optional per-requester beat counters
//   idx_w(n)    : index width for n requesters, never below 1 bit
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search.
//   req_i    : request vector, one bit per requester
//   start_i  : index at which the circular scan begins
//   any_o    : at least one request is set
//   winner_o : first set index scanning start_i, start_i+1, ..., wrapping
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         any_o,
  output logic [W-1:0] winner_o
);

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] s, input int k);
    int p;
    p = int'(s) + k;
    if (p >= N) p = p - N;
    return W'(p);
  endfunction

  // Scan from the far end back towards start so the last hit written is the
  // closest one to start_i in circular order.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_add(start_i, k)]) begin
        any_o    = 1'b1;
        winner_o = wrap_add(start_i, k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ requesters, granting bursts of up to MAX_BURST beats.
//
// Handshake: a requester word moves into the FIFO on a cycle where its
// req_valid and req_ready are both high (req_ready already includes
// fifo_wr_ready); the requester holds req_data stable while valid & ~ready.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid      : per-requester valid
//   req_data       : requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      : per-requester ready, only the granted one can be high
//   fifo_wr_en     : FIFO write enable (one per beat)
//   fifo_wr_data   : data slice of the granted requester
//   fifo_wr_ready  : FIFO not full
//   grant_idx      : current grant index
//   busy           : FSM is in GRANT (exposes arbiter state)
//   beat_cnt_bus   : only with FIFO_ARB_BEAT_CNT_EN, 16-bit saturating beat
//                    count per requester, requester i in bits [i*16 +: 16]
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_ready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
`ifdef FIFO_ARB_BEAT_CNT_EN
  , output logic [NUM_REQ*BEAT_CNT_W-1:0] beat_cnt_bus
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             busy_q;

  logic             beat;
  logic             last_beat;
  logic             rel;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] pick_start;
  logic             pick_any;
  logic [IDX_W-1:0] pick_winner;

  // Reset is folded in so a reset landing mid-burst never writes.
  assign beat      = (state_q == GRANT) & ~reset & req_valid[grant_q] & fifo_wr_ready;
  assign last_beat = beat & (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign rel       = (state_q == GRANT) & (last_beat | ~req_valid[grant_q]);
  assign next_idx  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // One picker serves both paths: IDLE starts at rr_ptr, a release starts
  // just past the releasing requester so it only wins again if alone.
  assign pick_start = (state_q == GRANT) ? next_idx : rr_ptr_q;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i    (req_valid),
    .start_i  (pick_start),
    .any_o    (pick_any),
    .winner_o (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_winner;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
            busy_q     <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            rr_ptr_q   <= next_idx;
            beat_cnt_q <= '0;
            if (pick_any) begin
              grant_q <= pick_winner;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == GRANT) && !reset) req_ready[grant_q] = fifo_wr_ready;
  end

  assign fifo_wr_en   = beat;
  assign fifo_wr_data = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_idx    = grant_q;
  assign busy         = busy_q;

`ifdef FIFO_ARB_BEAT_CNT_EN
  logic [NUM_REQ-1:0][BEAT_CNT_W-1:0] ev_cnt_q;

  // Saturate rather than wrap so a long-running source never reads as idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_cnt_q <= '0;
    end else if (beat && (ev_cnt_q[grant_q] != {BEAT_CNT_W{1'b1}})) begin
      ev_cnt_q[grant_q] <= ev_cnt_q[grant_q] + 1'b1;
    end
  end

  assign beat_cnt_bus = ev_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter (NUM_REQ=4,
// DATA_WIDTH=8, MAX_BURST=4). Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*DW-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    fifo_wr_en;
  logic [DW-1:0]           fifo_wr_data;
  logic                    fifo_wr_ready;
  logic [1:0]              grant_idx;
  logic                    busy;
`ifdef FIFO_ARB_BEAT_CNT_EN
  logic [NUM_REQ*16-1:0]   beat_cnt_bus;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_ready (fifo_wr_ready),
    .grant_idx     (grant_idx),
    .busy          (busy)
`ifdef FIFO_ARB_BEAT_CNT_EN
    , .beat_cnt_bus (beat_cnt_bus)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
      else check("sb_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    fifo_wr_ready = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // T1: single requester 1, two bursts back to back
    do_reset();
    settle();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_idx), 0);
    check("rst_rr_ptr", 32'(dut.rr_ptr_q), 0);
    check("rst_beat_cnt", 32'(dut.beat_cnt_q), 0);
    next_cycle();
    for (int b = 0; b < 6; b++) exp_q.push_back(8'(8'h10 + b));
    sb_on     = 1'b1;
    req_valid = 4'b0010;
    set_word(1, 8'h10);
    settle();
    check("t1_idle_wr_en", 32'(fifo_wr_en), 0);
    check("t1_idle_ready", 32'(req_ready), 0);
    next_cycle();
    for (int b = 0; b < 6; b++) begin
      settle();
      check("t1_wr_en", 32'(fifo_wr_en), 1);
      check("t1_grant", 32'(grant_idx), 1);
      check("t1_ready", 32'(req_ready), 32'b0010);
      if (b == 4) check("t1_rr_ptr", 32'(dut.rr_ptr_q), 2);
      next_cycle();
      set_word(1, 8'(8'h11 + b));
    end
    req_valid = '0;
    settle();
    check("t1_drop_wr_en", 32'(fifo_wr_en), 0);
    next_cycle();
    settle();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_sb_empty", 32'(exp_q.size()), 0);
    sb_on = 1'b0;

    // T2: all four requesters valid, grants rotate 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_word(i, 8'(i));
    for (int k = 0; k < 20; k++) exp_q.push_back(8'((k / 4) % 4));
    sb_on     = 1'b1;
    req_valid = 4'b1111;
    settle();
    check("t2_idle_busy", 32'(busy), 0);
    next_cycle();
    for (int k = 0; k < 20; k++) begin
      settle();
      check("t2_grant", 32'(grant_idx), 32'((k / 4) % 4));
      check("t2_wr_en", 32'(fifo_wr_en), 1);
      next_cycle();
    end
`ifdef FIFO_ARB_BEAT_CNT_EN
    check("t2_cnt0", 32'(beat_cnt_bus[0 +: 16]), 8);
    check("t2_cnt1", 32'(beat_cnt_bus[16 +: 16]), 4);
    check("t2_cnt2", 32'(beat_cnt_bus[32 +: 16]), 4);
    check("t2_cnt3", 32'(beat_cnt_bus[48 +: 16]), 4);
`endif
    req_valid = '0;
    settle();
    check("t2_drop_wr_en", 32'(fifo_wr_en), 0);
    next_cycle();
    check("t2_sb_empty", 32'(exp_q.size()), 0);
    sb_on = 1'b0;

    // T3: requester 2 drops after two beats, requester 3 takes over
    do_reset();
    set_word(2, 8'h22);
    set_word(3, 8'h33);
    req_valid = 4'b1100;
    settle();
    next_cycle();
    settle();
    check("t3_grant2", 32'(grant_idx), 2);
    check("t3_data2", 32'(fifo_wr_data), 32'h22);
    next_cycle();
    settle();
    check("t3_wr_en_b2", 32'(fifo_wr_en), 1);
    check("t3_cnt_b2", 32'(dut.beat_cnt_q), 1);
    next_cycle();
    req_valid = 4'b1000;
    settle();
    check("t3_drop_wr_en", 32'(fifo_wr_en), 0);
    check("t3_drop_busy", 32'(busy), 1);
    check("t3_drop_ready", 32'(req_ready), 32'b0100);
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      settle();
      check("t3_grant3", 32'(grant_idx), 3);
      check("t3_wr_en3", 32'(fifo_wr_en), 1);
      if (b == 0) begin
        check("t3_rr_ptr3", 32'(dut.rr_ptr_q), 3);
        check("t3_data3", 32'(fifo_wr_data), 32'h33);
      end
      next_cycle();
    end
    settle();
    check("t3_rr_ptr0", 32'(dut.rr_ptr_q), 0);
    check("t3_regrant3", 32'(grant_idx), 3);
    next_cycle();
    req_valid = '0;
    next_cycle();
    settle();
    check("t3_end_busy", 32'(busy), 0);
    next_cycle();

    // T4: back-pressure for 5 cycles mid-burst
    do_reset();
    set_word(0, 8'hA0);
    req_valid = 4'b0001;
    next_cycle();
    for (int b = 0; b < 2; b++) begin
      settle();
      check("t4_pre_wr_en", 32'(fifo_wr_en), 1);
      next_cycle();
    end
    fifo_wr_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      settle();
      check("t4_stall_wr_en", 32'(fifo_wr_en), 0);
      check("t4_stall_cnt", 32'(dut.beat_cnt_q), 2);
      check("t4_stall_busy", 32'(busy), 1);
      check("t4_stall_ready", 32'(req_ready), 0);
      next_cycle();
    end
    fifo_wr_ready = 1'b1;
    settle();
    check("t4_resume_wr_en", 32'(fifo_wr_en), 1);
    check("t4_resume_cnt", 32'(dut.beat_cnt_q), 2);
    next_cycle();
    settle();
    check("t4_last_wr_en", 32'(fifo_wr_en), 1);
    check("t4_last_cnt", 32'(dut.beat_cnt_q), 3);
    next_cycle();
    settle();
    check("t4_new_burst_cnt", 32'(dut.beat_cnt_q), 0);
    check("t4_new_burst_grant", 32'(grant_idx), 0);
    req_valid = '0;
    next_cycle();
    next_cycle();

    // T5: reset while granted with beat_cnt=3
    do_reset();
    req_valid = 4'b1111;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    settle();
    check("t5_cnt_before", 32'(dut.beat_cnt_q), 3);
    check("t5_rst_wr_en", 32'(fifo_wr_en), 0);
    next_cycle();
    reset = 1'b0;
    settle();
    check("t5_busy", 32'(busy), 0);
    check("t5_ready", 32'(req_ready), 0);
    check("t5_rr_ptr", 32'(dut.rr_ptr_q), 0);
    next_cycle();
    settle();
    check("t5_first_grant", 32'(grant_idx), 0);
    check("t5_first_wr_en", 32'(fifo_wr_en), 1);
    next_cycle();

`ifdef FIFO_ARB_BEAT_CNT_EN
    // T6: beat counter saturation
    do_reset();
    force dut.ev_cnt_q = {NUM_REQ{16'hFFFE}};
    settle();
    release dut.ev_cnt_q;
    next_cycle();
    req_valid = 4'b0001;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    settle();
    check("t6_sat_cnt0", 32'(beat_cnt_bus[0 +: 16]), 32'hFFFF);
    check("t6_idle_cnt1", 32'(beat_cnt_bus[16 +: 16]), 32'hFFFE);
    req_valid = '0;
    next_cycle();
`endif

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter sharing one FIFO write port among NUM_REQ requesters.
- Sits directly in front of the FIFO write port: fifo_wr_en and fifo_wr_data drive the FIFO, and fifo_wr_ready comes from the FIFO.
- A granted requester holds the port for a burst of up to MAX_BURST beats, so consecutive words from one source stay contiguous in the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 8, word width, equal to the FIFO DATA_WIDTH
- MAX_BURST, 4, maximum beats per grant (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester valid
- req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester ready
- fifo_wr_en  output  1  FIFO write enable
- fifo_wr_data  output  DATA_WIDTH  FIFO write data
- fifo_wr_ready  input  1  FIFO not full
- grant_idx  output  IDX_W  current grant index; IDX_W = max(1, clog2(NUM_REQ))
- busy  output  1  grant active (state GRANT)

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, busy=0.
  - req_ready=0 and fifo_wr_en=0 combinationally while in IDLE.
  - Reset mid-burst drops the grant with no write that cycle; the FIFO is reset by its own reset.
- Beat definition: beat = (state==GRANT) & req_valid[grant_idx] & fifo_wr_ready.
- Winner selection: the first index i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1.
- IDLE state:
  - No ready and no write.
  - If any req_valid=1: grant_idx<=winner, beat_cnt<=0, state<=GRANT.
  - Arbitration latency is 1 cycle; the first beat can occur in the cycle after the request.
- GRANT state:
  - req_ready[grant_idx] = fifo_wr_ready; all other req_ready = 0.
  - fifo_wr_en = beat; fifo_wr_data = slice grant_idx of req_data, driven regardless of valid.
  - A beat increments beat_cnt.
- Release condition: (beat & beat_cnt==MAX_BURST-1) or (req_valid[grant_idx]==0).
- On release:
  - rr_ptr <= grant_idx+1, wrapping to 0 at NUM_REQ.
  - Re-arbitrate in the same cycle over req_valid, scanning from grant_idx+1.
  - If there is a winner: grant_idx<=winner, beat_cnt<=0, stay in GRANT with no idle bubble. Otherwise state<=IDLE.
  - The releasing requester may win again only if no other requester is valid.
- Back-pressure:
  - fifo_wr_ready=0 in GRANT means no beat; beat_cnt and the grant hold.
  - There is no timeout; a full FIFO stalls the grant indefinitely.
  - A requester dropping valid while stalled still releases.
- Requesters must hold req_data stable while valid & ~ready; the arbiter does not check this.
- MAX_BURST=1 gives pure per-beat round robin: release on every beat.
- beat_cnt width is clog2(MAX_BURST+1) and never exceeds MAX_BURST-1.
- Non-granted requesters never see ready, so each beat writes exactly one word.

Optional Feature:
- Macro: FIFO_ARB_BEAT_CNT_EN.
- Defined:
  - Adds output beat_cnt_bus, NUM_REQ*16 bits.
  - Per-requester 16-bit counters increment on each beat of that requester and saturate at 16'hFFFF.
  - Counters clear on reset.
- Undefined: the port and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - State enum {IDLE, GRANT}.
  - Counter width constant BEAT_CNT_W=16.
  - Helper function for IDX_W (max(1, clog2(n))).
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and start pointer. Outputs: any_req and winner index.
  - Instantiated once; the IDLE and release paths share it with a muxed start pointer (rr_ptr in IDLE, grant_idx+1 on release).

Test Plan:
- Single requester, MAX_BURST=4, fifo_wr_ready=1, req_valid=4'b0010 held for 6 beats:
  - First write 1 cycle after valid.
  - Writes of data 0x10..0x13, a release cycle, re-grant to 1, then 0x14, 0x15.
  - grant_idx=1 throughout; no other ready.
- All four requesters valid continuously, data = index:
  - Grants rotate 0,1,2,3,0.
  - Each grant produces exactly 4 consecutive writes with no bubble between grants.
- Requester 2 drops valid after 2 beats while requester 3 is valid:
  - Release in the drop cycle; grant_idx=3 next cycle.
  - rr_ptr=3, then 0 after requester 3 completes.
- Back-pressure: fifo_wr_ready=0 for 5 cycles mid-burst:
  - fifo_wr_en=0 during the stall; beat_cnt holds at 2.
  - Grant kept; 2 remaining beats complete after ready returns.
- Reset asserted in GRANT with beat_cnt=3:
  - Next cycle busy=0, all req_ready=0, rr_ptr=0.
  - With all requesters valid, the first grant after reset goes to 0.
- FIFO_ARB_BEAT_CNT_EN defined:
  - After rotation test, each counter reads 4 per completed burst.
  - A counter forced near 16'hFFFF saturates and does not wrap.
